// File: rtl/regfile_mp_pkg.sv
// Shared register-file types and default sizes for the RV32I pipeline.
// rf_wr_t describes one write port; writeback_t is the legacy single-port view (write port 0).
package regfile_mp_pkg;

   localparam int XLEN_C   = 32;
   localparam int NREGS_C  = 32;
   localparam int REG_AW_C = 5;

   typedef struct packed {
      logic                wren;
      logic [REG_AW_C-1:0] rd_addr;
      logic [XLEN_C-1:0]   rd_data;
   } rf_wr_t;

   typedef rf_wr_t writeback_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the multi-port register file (flat packed port vectors).
interface regfile_mp_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 1
);
   localparam int AW = $clog2(NREGS);

   logic [NWR-1:0]      i_wr_en;
   logic [NWR*AW-1:0]   i_wr_addr;
   logic [NWR*XLEN-1:0] i_wr_data;
   logic [NRD*AW-1:0]   i_rd_addr;
   logic [NRD*XLEN-1:0] o_rd_data;
   logic [NRD-1:0]      o_rd_busy;
   logic                i_issue_en;
   logic [AW-1:0]       i_issue_rd;
   logic                i_flush;

   modport master (
      output i_wr_en, i_wr_addr, i_wr_data, i_rd_addr, i_issue_en, i_issue_rd, i_flush,
      input  o_rd_data, o_rd_busy
   );

   modport slave (
      input  i_wr_en, i_wr_addr, i_wr_data, i_rd_addr, i_issue_en, i_issue_rd, i_flush,
      output o_rd_data, o_rd_busy
   );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback or flush.
module regfile_mp_scoreboard #(
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 1,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic           i_clk,
   input  logic           i_rstn,
   input  logic [NWR-1:0] wr_en,
   input  logic [AW-1:0]  wr_addr [NWR],
   input  logic [AW-1:0]  rd_addr [NRD],
   input  logic           issue_en,
   input  logic [AW-1:0]  issue_rd,
   input  logic           flush,
   output logic [NRD-1:0] busy
);

   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pending_nxt;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

   // Lowest priority applied first so later assignments override: write clear, issue set, flush
   always_comb begin
      pending_nxt = pending;
      for (int p = 0; p < NWR; p++) begin
         if (wr_en[p] && wr_addr[p] != '0) begin
            pending_nxt[wr_addr[p]] = 1'b0;
         end
      end
      if (issue_en && issue_rd != '0) begin
         pending_nxt[issue_rd] = 1'b1;
      end
      if (flush) begin
         pending_nxt = '0;
      end
      pending_nxt[0] = 1'b0;
   end

   // A producer writing back this cycle is forwarded, so its consumer need not stall
   always_comb begin
      busy = '0;
      for (int r = 0; r < NRD; r++) begin
         busy[r] = (rd_addr[r] != '0) && pending[rd_addr[r]];
         if (BYPASS != 0) begin
            for (int p = 0; p < NWR; p++) begin
               if (wr_en[p] && wr_addr[p] == rd_addr[r]) begin
                  busy[r] = 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port RV32I integer register file with optional write-to-read bypass and RAW scoreboard.
// Reads are combinational; writes land on the rising edge, highest-index port winning conflicts.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int XLEN   = XLEN_C,
   parameter int NREGS  = NREGS_C,
   parameter int NRD    = 2,
   parameter int NWR    = 1,
   parameter int BYPASS = 1,
   parameter int SB_EN  = 1
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   regfile_mp_if.slave rf
);

   localparam int AW = $clog2(NREGS);

   logic [NWR-1:0]      wr_en;
   logic [AW-1:0]       wr_addr [NWR];
   logic [XLEN-1:0]     wr_data [NWR];
   logic [AW-1:0]       rd_addr [NRD];
   logic [XLEN-1:0]     regs    [NREGS];
   logic [NRD*XLEN-1:0] rd_data_flat;
   logic [NRD-1:0]      rd_busy;

   assign wr_en = rf.i_wr_en;

   for (genvar p = 0; p < NWR; p++) begin : g_wr_unpack
      assign wr_addr[p] = rf.i_wr_addr[p*AW +: AW];
      assign wr_data[p] = rf.i_wr_data[p*XLEN +: XLEN];
   end

   for (genvar r = 0; r < NRD; r++) begin : g_rd_unpack
      assign rd_addr[r] = rf.i_rd_addr[r*AW +: AW];
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int k = 0; k < NREGS; k++) begin
            regs[k] <= '0;
         end
      end else begin
         for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && wr_addr[p] != '0) begin
               regs[wr_addr[p]] <= wr_data[p];
            end
         end
      end
   end

   // Bypass is gated by reset so outputs read zero while reset is held
   for (genvar r = 0; r < NRD; r++) begin : g_rd
      logic [XLEN-1:0] val;
      always_comb begin
         val = (rd_addr[r] == '0) ? '0 : regs[rd_addr[r]];
         if (BYPASS != 0 && i_rstn && rd_addr[r] != '0) begin
            for (int p = 0; p < NWR; p++) begin
               if (wr_en[p] && wr_addr[p] == rd_addr[r]) begin
                  val = wr_data[p];
               end
            end
         end
      end
      assign rd_data_flat[r*XLEN +: XLEN] = val;
   end

   if (SB_EN != 0) begin : g_sb
      regfile_mp_scoreboard #(
         .NREGS (NREGS),
         .NRD   (NRD),
         .NWR   (NWR),
         .BYPASS(BYPASS)
      ) u_sb (
         .i_clk   (i_clk),
         .i_rstn  (i_rstn),
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .rd_addr (rd_addr),
         .issue_en(rf.i_issue_en),
         .issue_rd(rf.i_issue_rd),
         .flush   (rf.i_flush),
         .busy    (rd_busy)
      );
   end else begin : g_no_sb
      assign rd_busy = '0;
   end

   assign rf.o_rd_data = rd_data_flat;
   assign rf.o_rd_busy = rd_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 2-write bypassing instance and a 1-write non-bypassing instance.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus_a ();
   regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1)) bus_b ();

   regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .SB_EN(1)) dut_a (
      .i_clk(clk), .i_rstn(rstn), .rf(bus_a.slave));
   regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0), .SB_EN(1)) dut_b (
      .i_clk(clk), .i_rstn(rstn), .rf(bus_b.slave));

   int total = 0;
   int bad = 0;
   logic [31:0] exp_q [$];
   logic [31:0] want;
   logic [31:0] obs;
   logic [31:0] model [32];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_a.i_wr_en = '0; bus_a.i_wr_addr = '0; bus_a.i_wr_data = '0; bus_a.i_rd_addr = '0;
      bus_a.i_issue_en = 1'b0; bus_a.i_issue_rd = '0; bus_a.i_flush = 1'b0;
      bus_b.i_wr_en = '0; bus_b.i_wr_addr = '0; bus_b.i_wr_data = '0; bus_b.i_rd_addr = '0;
      bus_b.i_issue_en = 1'b0; bus_b.i_issue_rd = '0; bus_b.i_flush = 1'b0;
   endtask

   task automatic set_wr_a(input int p, input logic [4:0] a, input logic [31:0] d);
      bus_a.i_wr_en[p] = 1'b1;
      bus_a.i_wr_addr[p*5 +: 5] = a;
      bus_a.i_wr_data[p*32 +: 32] = d;
   endtask

   task automatic set_rd_a(input int r, input logic [4:0] a);
      bus_a.i_rd_addr[r*5 +: 5] = a;
   endtask

   task automatic set_wr_b(input logic [4:0] a, input logic [31:0] d);
      bus_b.i_wr_en[0] = 1'b1;
      bus_b.i_wr_addr = a;
      bus_b.i_wr_data = d;
   endtask

   task automatic test_reset();
      idle();
      rstn = 1'b0;
      set_rd_a(0, 5'd5);
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      want = exp_q.pop_front(); obs = bus_a.o_rd_data[31:0]; total++;
      if (obs !== want) begin bad++; $display("FAIL reset_data: got %h want %h", obs, want); end
      want = exp_q.pop_front(); obs = {31'b0, bus_a.o_rd_busy[0]}; total++;
      if (obs !== want) begin bad++; $display("FAIL reset_busy: got %h want %h", obs, want); end
      rstn = 1'b1;
      step(); idle();
      set_wr_a(0, 5'd5, 32'hDEADBEEF);
      bus_a.i_issue_en = 1'b1; bus_a.i_issue_rd = 5'd5;
      step(); idle();
      set_rd_a(0, 5'd5);
      exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h1);
      #1;
      want = exp_q.pop_front(); obs = bus_a.o_rd_data[31:0]; total++;
      if (obs !== want) begin bad++; $display("FAIL pre_reset_data: got %h want %h", obs, want); end
      want = exp_q.pop_front(); obs = {31'b0, bus_a.o_rd_busy[0]}; total++;
      if (obs !== want) begin bad++; $display("FAIL pre_reset_busy: got %h want %h", obs, want); end
      // mid-cycle reset with a bypassable write in flight
      rstn = 1'b0;
      set_wr_a(0, 5'd5, 32'h0BADF00D);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      want = exp_q.pop_front(); obs = bus_a.o_rd_data[31:0]; total++;
      if (obs !== want) begin bad++; $display("FAIL midreset_data: got %h want %h", obs, want); end
      want = exp_q.pop_front(); obs = {31'b0, bus_a.o_rd_busy[0]}; total++;
      if (obs !== want) begin bad++; $display("FAIL midreset_busy: got %h want %h", obs, want); end
      step(); idle();
      set_rd_a(0, 5'd5);
      #2;
      rstn = 1'b1;
      exp_q.push_back(32'h0);
      #1;
      want = exp_q.pop_front(); obs = bus_a.o_rd_data[31:0]; total++;
      if (obs !== want) begin bad++; $display("FAIL write_in_reset: got %h want %h", obs, want); end
   endtask

   task automatic test_x0();
      step(); idle();
      set_wr_a(0, 5'd0, 32'hFFFFFFFF);
      bus_a.i_issue_en = 1'b1; bus_a.i_issue_rd = 5'd0;
      set_rd_a(0, 5'd0);
      exp_q.push_back(32'h0);
      #1;
      want = exp_q.pop_front(); obs = bus_a.o_rd_data[31:0]; total++;
      if (obs !== want) begin bad++; $display("FAIL x0_no_bypass: got %h want %h", obs, want); end
      step(); idle();
      set_rd_a(0, 5'd0);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      want = exp_q.pop_front(); obs = bus_a.o_rd_data[31:0]; total++;
      if (obs !== want) begin bad++; $display("FAIL x0_data: got %h want %h", obs, want); end
      want = exp_q.pop_front(); obs = {31'b0, bus_a.o_rd_busy[0]}; total++;
      if (obs !== want) begin bad++; $display("FAIL x0_busy: got %h want %h", obs, want); end
   endtask

   task automatic test_bypass();
      step(); idle();
      set_wr_a(0, 5'd7, 32'hAAAA0000);
      set_wr_b(5'd7, 32'hAAAA0000);
      step(); idle();
      set_wr_a(0, 5'd7, 32'h12345678); set_rd_a(1, 5'd7);
      set_wr_b(5'd7, 32'h12345678); bus_b.i_rd_addr[9:5] = 5'd7;
      exp_q.push_back(32'h12345678); exp_q.push_back(32'hAAAA0000);
      #1;
      want = exp_q.pop_front(); obs = bus_a.o_rd_data[63:32]; total++;
      if (obs !== want) begin bad++; $display("FAIL bypass_on: got %h want %h", obs, want); end
      want = exp_q.pop_front(); obs = bus_b.o_rd_data[63:32]; total++;
      if (obs !== want) begin bad++; $display("FAIL bypass_off_old: got %h want %h", obs, want); end
      step(); idle();
      bus_b.i_rd_addr[9:5] = 5'd7;
      exp_q.push_back(32'h12345678);
      #1;
      want = exp_q.pop_front(); obs = bus_b.o_rd_data[63:32]; total++;
      if (obs !== want) begin bad++; $display("FAIL bypass_off_new: got %h want %h", obs, want); end
   endtask

   task automatic test_conflict();
      step(); idle();
      set_wr_a(0, 5'd3, 32'h11); set_wr_a(1, 5'd3, 32'h22);
      set_rd_a(0, 5'd3);
      exp_q.push_back(32'h22);
      #1;
      want = exp_q.pop_front(); obs = bus_a.o_rd_data[31:0]; total++;
      if (obs !== want) begin bad++; $display("FAIL conflict_bypass: got %h want %h", obs, want); end
      step(); idle();
      set_rd_a(0, 5'd3); set_rd_a(1, 5'd3);
      exp_q.push_back(32'h22); exp_q.push_back(32'h22);
      #1;
      want = exp_q.pop_front(); obs = bus_a.o_rd_data[31:0]; total++;
      if (obs !== want) begin bad++; $display("FAIL conflict_p0: got %h want %h", obs, want); end
      want = exp_q.pop_front(); obs = bus_a.o_rd_data[63:32]; total++;
      if (obs !== want) begin bad++; $display("FAIL conflict_p1: got %h want %h", obs, want); end
   endtask

   task automatic test_scoreboard();
      step(); idle();
      bus_a.i_issue_en = 1'b1; bus_a.i_issue_rd = 5'd9;
      step(); idle();
      set_rd_a(1, 5'd9);
      exp_q.push_back(32'h1);
      #1;
      want = exp_q.pop_front(); obs = {31'b0, bus_a.o_rd_busy[1]}; total++;
      if (obs !== want) begin bad++; $display("FAIL sb_issue: got %h want %h", obs, want); end
      step(); idle();
      set_wr_a(0, 5'd9, 32'h99); set_rd_a(1, 5'd9);
      exp_q.push_back(32'h0); exp_q.push_back(32'h99);
      #1;
      want = exp_q.pop_front(); obs = {31'b0, bus_a.o_rd_busy[1]}; total++;
      if (obs !== want) begin bad++; $display("FAIL sb_wb_same: got %h want %h", obs, want); end
      want = exp_q.pop_front(); obs = bus_a.o_rd_data[63:32]; total++;
      if (obs !== want) begin bad++; $display("FAIL sb_wb_fwd: got %h want %h", obs, want); end
      step(); idle();
      set_rd_a(1, 5'd9);
      exp_q.push_back(32'h0);
      #1;
      want = exp_q.pop_front(); obs = {31'b0, bus_a.o_rd_busy[1]}; total++;
      if (obs !== want) begin bad++; $display("FAIL sb_wb_after: got %h want %h", obs, want); end
      step(); idle();
      bus_a.i_issue_en = 1'b1; bus_a.i_issue_rd = 5'd9;
      set_wr_a(1, 5'd9, 32'h98);
      step(); idle();
      set_rd_a(1, 5'd9);
      exp_q.push_back(32'h1); exp_q.push_back(32'h98);
      #1;
      want = exp_q.pop_front(); obs = {31'b0, bus_a.o_rd_busy[1]}; total++;
      if (obs !== want) begin bad++; $display("FAIL sb_issue_wins: got %h want %h", obs, want); end
      want = exp_q.pop_front(); obs = bus_a.o_rd_data[63:32]; total++;
      if (obs !== want) begin bad++; $display("FAIL sb_issue_data: got %h want %h", obs, want); end
      step(); idle();
      set_wr_a(0, 5'd9, 32'h0);
   endtask

   task automatic test_flush();
      step(); idle();
      bus_a.i_issue_en = 1'b1; bus_a.i_issue_rd = 5'd4;
      step(); idle();
      bus_a.i_issue_en = 1'b1; bus_a.i_issue_rd = 5'd6;
      set_rd_a(0, 5'd4);
      exp_q.push_back(32'h1);
      #1;
      want = exp_q.pop_front(); obs = {31'b0, bus_a.o_rd_busy[0]}; total++;
      if (obs !== want) begin bad++; $display("FAIL flush_pre_x4: got %h want %h", obs, want); end
      step(); idle();
      bus_a.i_flush = 1'b1; bus_a.i_issue_en = 1'b1; bus_a.i_issue_rd = 5'd8;
      set_rd_a(0, 5'd4); set_rd_a(1, 5'd6);
      exp_q.push_back(32'h1); exp_q.push_back(32'h1);
      #1;
      want = exp_q.pop_front(); obs = {31'b0, bus_a.o_rd_busy[0]}; total++;
      if (obs !== want) begin bad++; $display("FAIL flush_same_x4: got %h want %h", obs, want); end
      want = exp_q.pop_front(); obs = {31'b0, bus_a.o_rd_busy[1]}; total++;
      if (obs !== want) begin bad++; $display("FAIL flush_same_x6: got %h want %h", obs, want); end
      step(); idle();
      set_rd_a(0, 5'd4); set_rd_a(1, 5'd6);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      want = exp_q.pop_front(); obs = {31'b0, bus_a.o_rd_busy[0]}; total++;
      if (obs !== want) begin bad++; $display("FAIL flush_x4: got %h want %h", obs, want); end
      want = exp_q.pop_front(); obs = {31'b0, bus_a.o_rd_busy[1]}; total++;
      if (obs !== want) begin bad++; $display("FAIL flush_x6: got %h want %h", obs, want); end
      set_rd_a(0, 5'd8);
      exp_q.push_back(32'h0);
      #1;
      want = exp_q.pop_front(); obs = {31'b0, bus_a.o_rd_busy[0]}; total++;
      if (obs !== want) begin bad++; $display("FAIL flush_x8: got %h want %h", obs, want); end
   endtask

   task automatic test_back_to_back();
      logic        e0, e1;
      logic [4:0]  a0, a1, ra;
      logic [31:0] d0, d1, ev;
      step(); idle();
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
      for (int k = 0; k < 32; k++) model[k] = 32'h0;
      for (int c = 0; c < 24; c++) begin
         step(); idle();
         e0 = 1'($urandom_range(0, 1)); e1 = 1'($urandom_range(0, 1));
         a0 = 5'($urandom_range(0, 31)); a1 = (c % 4 == 0) ? a0 : 5'($urandom_range(0, 31));
         d0 = $urandom; d1 = $urandom;
         ra = (c % 3 == 0) ? a1 : 5'($urandom_range(0, 31));
         if (e0) set_wr_a(0, a0, d0);
         if (e1) set_wr_a(1, a1, d1);
         set_rd_a(0, ra);
         ev = model[ra];
         if (ra != 5'd0 && e0 && a0 == ra) ev = d0;
         if (ra != 5'd0 && e1 && a1 == ra) ev = d1;
         exp_q.push_back(ev);
         if (e0 && a0 != 5'd0) model[a0] = d0;
         if (e1 && a1 != 5'd0) model[a1] = d1;
         #1;
         want = exp_q.pop_front(); obs = bus_a.o_rd_data[31:0]; total++;
         if (obs !== want) begin bad++; $display("FAIL b2b_rd x%0d: got %h want %h", ra, obs, want); end
      end
      for (int k = 0; k < 16; k++) begin
         step(); idle();
         set_rd_a(0, 5'(2*k)); set_rd_a(1, 5'(2*k+1));
         exp_q.push_back(model[2*k]); exp_q.push_back(model[2*k+1]);
         #1;
         want = exp_q.pop_front(); obs = bus_a.o_rd_data[31:0]; total++;
         if (obs !== want) begin bad++; $display("FAIL b2b_dump x%0d: got %h want %h", 2*k, obs, want); end
         want = exp_q.pop_front(); obs = bus_a.o_rd_data[63:32]; total++;
         if (obs !== want) begin bad++; $display("FAIL b2b_dump x%0d: got %h want %h", 2*k+1, obs, want); end
      end
   endtask

   initial begin
      test_reset();
      test_x0();
      test_bypass();
      test_conflict();
      test_scoreboard();
      test_flush();
      test_back_to_back();
      step(); idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
